// File: rtl/rv32i_types.sv
// Shared RV32I types: the decode -> load/store queue entry, the queue FSM states
// and the load/store funct3 encodings.
package rv32i_types;

  localparam int ROB_ID_SIZE = 4;

  typedef struct packed {
    logic                   valid;
    logic                   mem_inst;
    logic                   l_s;          // 1 = load, 0 = store
    logic [2:0]             funct3;
    logic [31:0]            rs1_v;
    logic                   r1;           // rs1_v holds the real value
    logic [ROB_ID_SIZE-1:0] rob_id;       // producer of rs1 while !r1
    logic [31:0]            rs2_v;
    logic                   r2;
    logic [ROB_ID_SIZE-1:0] rob_id2;
    logic [31:0]            ls_imm;
    logic [ROB_ID_SIZE-1:0] rob_id_dest;
  } ls_q_entry;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} lsq_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsq_mem_align.sv
// Combinational memory alignment: builds the word-aligned request (address,
// byte masks, lane-shifted store data) and extracts/extends returned load data.
module lsq_mem_align
  import rv32i_types::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [2:0]  funct3,
  input  logic        is_load,
  input  logic [31:0] st_data,
  output logic [31:0] addr,
  output logic [1:0]  off,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ea;
  logic [3:0]  mask;
  logic [31:0] sh;

  // Request side: effective address, size mask, store lane shift
  always_comb begin
    ea         = base + imm;
    addr       = {ea[31:2], 2'b00};
    off        = ea[1:0];
    mask       = 4'b1111;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00:   mask = 4'b0001 << off;
      2'b01: begin
        mask       = 4'b0011 << off;
        misaligned = off[0];
      end
      default: misaligned = |off;
    endcase
    rmask = is_load ? mask : 4'b0000;
    wmask = is_load ? 4'b0000 : mask;
    wdata = is_load ? 32'h0 : (st_data << {off, 3'b000});
  end

  // Response side: shift the addressed lane down, then sign/zero extend
  always_comb begin
    sh = rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_LB:   ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  ld_data = {24'h0, sh[7:0]};
      F3_LHU:  ld_data = {16'h0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue: buffers memory ops from decode, wakes operands off
// the CDB, and issues one dmem request at a time in program order.
module ls_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 8,
  parameter int ROB_W = ROB_ID_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  ls_q_entry        ls_q_inst1,
  output logic             ls_q_full,
  input  logic             flush,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_rob_id,
  input  logic [31:0]      cdb_data,
  input  logic             rob_head_valid,
  input  logic [ROB_W-1:0] rob_head_id,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_rmask,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic             ld_valid,
  output logic [ROB_W-1:0] ld_rob_id,
  output logic [31:0]      ld_data,
  output logic             st_done,
  output logic [ROB_W-1:0] st_rob_id
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ls_q_entry        q_q [DEPTH];
  ls_q_entry        q_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  lsq_state_t       state_q, state_d;

  // Registered request and writeback outputs
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, ld_data_q, ld_data_d;
  logic [3:0]       rmask_q, rmask_d, wmask_q, wmask_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic             is_load_q, is_load_d;
  logic [ROB_W-1:0] dest_q, dest_d, ld_rob_id_q, ld_rob_id_d, st_rob_id_q, st_rob_id_d;
  logic             ld_valid_q, ld_valid_d, st_done_q, st_done_d;

  ls_q_entry        hd, in_snoop;
  logic             enq, pop, clr_q, clr_req, eligible;
  logic [31:0]      al_addr, al_wdata, al_ld_data;
  logic [1:0]       al_off;
  logic [3:0]       al_rmask, al_wmask;
  logic             al_misaligned;

  assign hd        = q_q[head_q];
  assign ls_q_full = (count_q == CW'(DEPTH));
  assign eligible  = hd.valid && hd.r1 && hd.r2 &&
                     (hd.l_s || (rob_head_valid && hd.rob_id_dest == rob_head_id));

  lsq_mem_align u_align (
    .base      (hd.rs1_v),
    .imm       (hd.ls_imm),
    .funct3    (hd.funct3),
    .is_load   (hd.l_s),
    .st_data   (hd.rs2_v),
    .addr      (al_addr),
    .off       (al_off),
    .rmask     (al_rmask),
    .wmask     (al_wmask),
    .wdata     (al_wdata),
    .misaligned(al_misaligned),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .rdata     (dmem_rdata),
    .ld_data   (al_ld_data)
  );

  assign dmem_addr  = addr_q;
  assign dmem_rmask = rmask_q;
  assign dmem_wmask = wmask_q;
  assign dmem_wdata = wdata_q;
  assign ld_valid   = ld_valid_q;
  assign ld_rob_id  = ld_rob_id_q;
  assign ld_data    = ld_data_q;
  assign st_done    = st_done_q;
  assign st_rob_id  = st_rob_id_q;

  // Next state: wakeup, FSM, pop/enqueue, flush
  always_comb begin
    q_d         = q_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    addr_d      = addr_q;
    rmask_d     = rmask_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    off_d       = off_q;
    f3_d        = f3_q;
    is_load_d   = is_load_q;
    dest_d      = dest_q;
    ld_valid_d  = 1'b0;
    ld_rob_id_d = '0;
    ld_data_d   = '0;
    st_done_d   = 1'b0;
    st_rob_id_d = '0;
    pop         = 1'b0;
    clr_q       = 1'b0;
    clr_req     = 1'b0;
    enq         = ls_q_inst1.valid && ls_q_inst1.mem_inst && !ls_q_full && !flush;

    // The incoming entry sees the same CDB broadcast as resident entries
    in_snoop = ls_q_inst1;
    if (cdb_valid && !in_snoop.r1 && in_snoop.rob_id == cdb_rob_id) begin
      in_snoop.rs1_v = cdb_data;
      in_snoop.r1    = 1'b1;
    end
    if (cdb_valid && !in_snoop.r2 && in_snoop.rob_id2 == cdb_rob_id) begin
      in_snoop.rs2_v = cdb_data;
      in_snoop.r2    = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && q_q[i].valid && !q_q[i].r1 && q_q[i].rob_id == cdb_rob_id) begin
        q_d[i].rs1_v = cdb_data;
        q_d[i].r1    = 1'b1;
      end
      if (cdb_valid && q_q[i].valid && !q_q[i].r2 && q_q[i].rob_id2 == cdb_rob_id) begin
        q_d[i].rs2_v = cdb_data;
        q_d[i].r2    = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (flush) begin
          clr_q = 1'b1;
        end else if (eligible) begin
          addr_d    = al_addr;
          rmask_d   = al_rmask;
          wmask_d   = al_wmask;
          wdata_d   = al_wdata;
          off_d     = al_off;
          f3_d      = hd.funct3;
          is_load_d = hd.l_s;
          dest_d    = hd.rob_id_dest;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          // Only a load can be outstanding here; its response is dropped
          clr_q = 1'b1;
          if (dmem_resp) begin
            clr_req = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (dmem_resp) begin
          pop     = 1'b1;
          clr_req = 1'b1;
          state_d = IDLE;
          if (is_load_q) begin
            ld_valid_d  = 1'b1;
            ld_rob_id_d = dest_q;
            ld_data_d   = al_ld_data;
          end else begin
            st_done_d   = 1'b1;
            st_rob_id_d = dest_q;
          end
        end
      end
      DRAIN: begin
        if (flush) clr_q = 1'b1;
        if (dmem_resp) begin
          clr_req = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_req) begin
      addr_d    = '0;
      rmask_d   = '0;
      wmask_d   = '0;
      wdata_d   = '0;
      off_d     = '0;
      f3_d      = '0;
      is_load_d = 1'b0;
      dest_d    = '0;
    end

    // Pop and enqueue never alias: enqueue needs !full, pop needs non-empty
    if (pop) begin
      q_d[head_q].valid = 1'b0;
      head_d            = head_q + PW'(1);
    end
    if (enq) begin
      q_d[tail_q] = in_snoop;
      tail_d      = tail_q + PW'(1);
    end
    case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (clr_q) begin
      for (int i = 0; i < DEPTH; i++) q_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      addr_q      <= '0;
      rmask_q     <= '0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      is_load_q   <= 1'b0;
      dest_q      <= '0;
      ld_valid_q  <= 1'b0;
      ld_rob_id_q <= '0;
      ld_data_q   <= '0;
      st_done_q   <= 1'b0;
      st_rob_id_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      rmask_q     <= rmask_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      is_load_q   <= is_load_d;
      dest_q      <= dest_d;
      ld_valid_q  <= ld_valid_d;
      ld_rob_id_q <= ld_rob_id_d;
      ld_data_q   <= ld_data_d;
      st_done_q   <= st_done_d;
      st_rob_id_q <= st_rob_id_d;
    end
  end

  // A store in flight is the ROB head, so it can never be flushed
  a_no_store_flush: assert property (@(posedge clk) disable iff (!rst)
    !(state_q == REQ && flush && !is_load_q));

  // Sub-word alignment faults are not handled by this queue
  a_aligned: assert property (@(posedge clk) disable iff (!rst)
    !(state_q == IDLE && !flush && eligible && al_misaligned));

endmodule

// File: tb/tb_ls_queue.sv
// Directed bench for ls_queue: loads, stores, CDB wakeup, full/wrap, flush.
module tb_ls_queue;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  ls_q_entry   ls_q_inst1;
  logic        ls_q_full;
  logic        flush;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_data;
  logic        rob_head_valid;
  logic [3:0]  rob_head_id;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        ld_valid;
  logic [3:0]  ld_rob_id;
  logic [31:0] ld_data;
  logic        st_done;
  logic [3:0]  st_rob_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ls_queue #(.DEPTH(8), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .ls_q_inst1(ls_q_inst1), .ls_q_full(ls_q_full),
    .flush(flush), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .rob_head_valid(rob_head_valid), .rob_head_id(rob_head_id),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .ld_valid(ld_valid), .ld_rob_id(ld_rob_id), .ld_data(ld_data),
    .st_done(st_done), .st_rob_id(st_rob_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ls_q_entry mk(input logic ld, input logic [2:0] f3,
                                   input logic [31:0] rs1, input logic r1, input logic [3:0] id1,
                                   input logic [31:0] rs2, input logic [31:0] imm,
                                   input logic [3:0] dest);
    ls_q_entry e;
    e = '0;
    e.valid = 1'b1; e.mem_inst = 1'b1; e.l_s = ld; e.funct3 = f3;
    e.rs1_v = rs1; e.r1 = r1; e.rob_id = id1;
    e.rs2_v = rs2; e.r2 = 1'b1; e.rob_id2 = 4'd0;
    e.ls_imm = imm; e.rob_id_dest = dest;
    return e;
  endfunction

  // Present one entry for one cycle
  task automatic enq(input ls_q_entry e);
    ls_q_inst1 = e;
    @(posedge clk); #1;
    ls_q_inst1 = '0;
  endtask

  // Wait (bounded) until a request is on the bus; ends on a negedge
  task automatic wait_req(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dmem_rmask != 4'b0 || dmem_wmask != 4'b0) seen = 1'b1;
    end
    chk(tag, {31'h0, seen}, 32'h1);
  endtask

  // One-cycle dmem_resp, optionally with a same-cycle enqueue; ends at posedge+1
  task automatic resp(input logic [31:0] rd, input logic do_enq, input ls_q_entry e);
    @(posedge clk); #1;
    dmem_resp = 1'b1; dmem_rdata = rd;
    if (do_enq) ls_q_inst1 = e;
    @(posedge clk); #1;
    dmem_resp = 1'b0; ls_q_inst1 = '0;
  endtask

  initial begin
    rst = 1'b0; ls_q_inst1 = '0; flush = 1'b0; cdb_valid = 1'b0; cdb_rob_id = '0;
    cdb_data = '0; rob_head_valid = 1'b0; rob_head_id = '0; dmem_rdata = '0; dmem_resp = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_full",  {31'h0, ls_q_full}, 32'h0);
    chk("rst_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
    chk("rst_addr",  dmem_addr, 32'h0);
    chk("rst_pulse", {30'h0, ld_valid, st_done}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // lw 0x1000+4
    enq(mk(1'b1, F3_LW, 32'h1000, 1'b1, 4'd0, 32'h0, 32'h4, 4'd5));
    wait_req("lw_req");
    chk("lw_addr",  dmem_addr, 32'h1004);
    chk("lw_rmask", {28'h0, dmem_rmask}, 32'hF);
    chk("lw_wmask", {28'h0, dmem_wmask}, 32'h0);
    @(negedge clk);
    chk("lw_hold", {dmem_addr[27:0], dmem_rmask}, {28'h0001004, 4'hF});
    resp(32'hDEADBEEF, 1'b0, '0);
    @(negedge clk);
    chk("lw_ldv",   {31'h0, ld_valid}, 32'h1);
    chk("lw_data",  ld_data, 32'hDEADBEEF);
    chk("lw_robid", {28'h0, ld_rob_id}, 32'h5);
    chk("lw_mask0", {28'h0, dmem_rmask}, 32'h0);
    @(negedge clk);
    chk("lw_pulse", {31'h0, ld_valid}, 32'h0);

    // lb then lbu at 0x1003
    enq(mk(1'b1, F3_LB, 32'h1000, 1'b1, 4'd0, 32'h0, 32'h3, 4'd6));
    enq(mk(1'b1, F3_LBU, 32'h1000, 1'b1, 4'd0, 32'h0, 32'h3, 4'd7));
    wait_req("lb_req");
    chk("lb_addr",  dmem_addr, 32'h1000);
    chk("lb_rmask", {28'h0, dmem_rmask}, 32'h8);
    resp(32'h80123456, 1'b0, '0);
    @(negedge clk);
    chk("lb_data", ld_data, 32'hFFFFFF80);
    wait_req("lbu_req");
    chk("lbu_rmask", {28'h0, dmem_rmask}, 32'h8);
    resp(32'h80123456, 1'b0, '0);
    @(negedge clk);
    chk("lbu_data", ld_data, 32'h00000080);
    chk("lbu_robid", {28'h0, ld_rob_id}, 32'h7);

    // sh at 0x2002 waits for ROB head
    rob_head_valid = 1'b1; rob_head_id = 4'd2;
    enq(mk(1'b0, F3_SH, 32'h2000, 1'b1, 4'd0, 32'h1234, 32'h2, 4'd9));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("sh_wait", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
    end
    rob_head_id = 4'd9;
    wait_req("sh_req");
    chk("sh_addr",  dmem_addr, 32'h2000);
    chk("sh_wmask", {24'h0, dmem_rmask, dmem_wmask}, 32'h0C);
    chk("sh_wdata", dmem_wdata, 32'h12340000);
    resp(32'h0, 1'b0, '0);
    @(negedge clk);
    chk("sh_done", {31'h0, st_done}, 32'h1);
    chk("sh_robid", {28'h0, st_rob_id}, 32'h9);
    chk("sh_noldv", {31'h0, ld_valid}, 32'h0);
    rob_head_valid = 1'b0;

    // Wakeup of the incoming entry in its enqueue cycle
    cdb_valid = 1'b1; cdb_rob_id = 4'd3; cdb_data = 32'h40;
    enq(mk(1'b1, F3_LW, 32'h0, 1'b0, 4'd3, 32'h0, 32'h8, 4'd1));
    cdb_valid = 1'b0;
    wait_req("snoop_req");
    chk("snoop_addr", dmem_addr, 32'h48);
    resp(32'h11112222, 1'b0, '0);
    @(negedge clk);
    chk("snoop_data", ld_data, 32'h11112222);

    // Flush while idle resets pointers, then fill 8 loads waiting on rob 9
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 8; i++)
      enq(mk(1'b1, F3_LW, 32'h0, 1'b0, 4'd9, 32'h0, 32'(i * 4), 4'(i)));
    @(negedge clk);
    chk("fill_full", {31'h0, ls_q_full}, 32'h1);
    enq(mk(1'b1, F3_LW, 32'h0, 1'b0, 4'd9, 32'h0, 32'h100, 4'd8));
    cdb_valid = 1'b1; cdb_rob_id = 4'd9; cdb_data = 32'h3000;
    @(posedge clk); #1 cdb_valid = 1'b0;
    wait_req("full_req0");
    chk("full_addr0", dmem_addr, 32'h3000);
    // Pop while full: the concurrent enqueue is still refused
    resp(32'h0, 1'b1, mk(1'b1, F3_LW, 32'h3000, 1'b1, 4'd0, 32'h0, 32'h100, 4'd8));
    @(negedge clk);
    chk("pop_full_drop", {31'h0, ls_q_full}, 32'h0);
    wait_req("full_req1");
    chk("full_addr1", dmem_addr, 32'h3004);
    // Pop + enqueue at 7 entries: count unchanged, tail wraps into slot 0
    resp(32'h0, 1'b1, mk(1'b1, F3_LW, 32'h3000, 1'b1, 4'd0, 32'h0, 32'h200, 4'd10));
    @(negedge clk);
    chk("popenq_cnt", {31'h0, ls_q_full}, 32'h0);
    enq(mk(1'b1, F3_LW, 32'h3000, 1'b1, 4'd0, 32'h0, 32'h300, 4'd11));
    @(negedge clk);
    chk("refill_full", {31'h0, ls_q_full}, 32'h1);
    for (int i = 2; i < 8; i++) begin
      wait_req("order_req");
      chk("order_addr", dmem_addr, 32'h3000 + 32'(i * 4));
      resp(32'h0, 1'b0, '0);
    end
    wait_req("wrap_req0");
    chk("wrap_addr0", dmem_addr, 32'h3200);
    resp(32'h0, 1'b0, '0);
    wait_req("wrap_req1");
    chk("wrap_addr1", dmem_addr, 32'h3300);
    resp(32'h0, 1'b0, '0);
    @(negedge clk);
    chk("empty_full", {31'h0, ls_q_full}, 32'h0);

    // Flush with a load outstanding: response discarded, younger load gone
    enq(mk(1'b1, F3_LW, 32'h4000, 1'b1, 4'd0, 32'h0, 32'h0, 4'd2));
    enq(mk(1'b1, F3_LW, 32'h5000, 1'b1, 4'd0, 32'h0, 32'h0, 4'd3));
    wait_req("fl_req");
    chk("fl_addr", dmem_addr, 32'h4000);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("fl_hold", {dmem_addr[27:0], dmem_rmask}, {28'h0004000, 4'hF});
    @(posedge clk);
    resp(32'hCAFEF00D, 1'b0, '0);
    @(negedge clk);
    chk("fl_noldv", {31'h0, ld_valid}, 32'h0);
    chk("fl_mask0", {28'h0, dmem_rmask}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fl_idle", {24'h0, dmem_rmask, dmem_wmask, 3'b0, ld_valid}, 32'h0);
    end
    enq(mk(1'b1, F3_LW, 32'h6000, 1'b1, 4'd0, 32'h0, 32'h0, 4'd4));
    wait_req("post_fl_req");
    chk("post_fl_addr", dmem_addr, 32'h6000);
    resp(32'h12345678, 1'b0, '0);
    @(negedge clk);
    chk("post_fl_ldv",  {31'h0, ld_valid}, 32'h1);
    chk("post_fl_data", ld_data, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
